// File: rtl/stack_ctrl_if.sv
// Command-side handshake bundle for stack_ctrl: push/pop requests, completion and occupancy status.
// The master modport is the CPU control unit; the slave modport is the stack sequencer.
interface stack_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] wr_data;
    logic                 ready;
    logic                 ack;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 full;
    logic                 empty;
    logic                 err;

    modport master (
        output push, pop, wr_data,
        input  ready, ack, rd_data, rd_valid, full, empty, err
    );

    modport slave (
        input  push, pop, wr_data,
        output ready, ack, rd_data, rd_valid, full, empty, err
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop sequencer driving the external sp counter and synchronous stack RAM.
// Optional macro STACK_GUARD_EN: overflow/underflow commands are consumed without effect and set sticky err.
module stack_ctrl #(
    parameter int BITS      = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_ctrl_if.slave          bus,
    input  logic [BITS-1:0]      sp,
    output logic                 sp_we,
    output logic                 sp_op,
    output logic [BITS-1:0]      mem_addr,
    output logic                 mem_we,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);
    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_DEC,
        POP_RD,
        POP_CAP
    } state_t;

    localparam logic [BITS:0] FULL_COUNT = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0] COUNT_ONE  = (BITS + 1)'(1);

    state_t               state_q, state_d;
    logic [BITS:0]        count_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 rd_valid_q;
    logic                 load_wdata;
    logic                 reject;
    logic                 guard_push;
    logic                 guard_pop;

    assign bus.ready    = (state_q == IDLE);
    assign bus.full     = (count_q == FULL_COUNT);
    assign bus.empty    = (count_q == '0);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    // sp already points at the right slot in every state: next free slot for a push,
    // the decremented top-of-stack by the time POP_RD presents the read.
    assign mem_addr  = sp;
    assign mem_wdata = wdata_q;

`ifdef STACK_GUARD_EN
    logic err_q;

    assign guard_push = bus.full;
    assign guard_pop  = bus.empty;
    assign bus.err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err_q <= 1'b0;
        else if (reject) err_q <= 1'b1;
    end
`else
    assign guard_push = 1'b0;
    assign guard_pop  = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     count_q <= '0;
        else if (state_q == PUSH)    count_q <= count_q + COUNT_ONE;
        else if (state_q == POP_DEC) count_q <= count_q - COUNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == POP_CAP);
            if (state_q == POP_CAP) rd_data_q <= mem_rdata;
        end
    end

    // NOTE: the push-word holding register has no reset; it is only observed in PUSH, after a load.
    always_ff @(posedge clk) begin
        if (load_wdata) wdata_q <= bus.wr_data;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        sp_we      = 1'b0;
        sp_op      = 1'b0;
        mem_we     = 1'b0;
        bus.ack    = 1'b0;
        load_wdata = 1'b0;
        reject     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Push wins a tie; a held pop is picked up on the next IDLE cycle.
                if (bus.push) begin
                    if (guard_push) begin
                        reject  = 1'b1;
                        bus.ack = 1'b1;
                    end else begin
                        load_wdata = 1'b1;
                        state_d    = PUSH;
                    end
                end else if (bus.pop) begin
                    if (guard_pop) begin
                        reject  = 1'b1;
                        bus.ack = 1'b1;
                    end else begin
                        state_d = POP_DEC;
                    end
                end
            end
            PUSH: begin
                mem_we  = 1'b1;
                sp_we   = 1'b1;
                sp_op   = 1'b1;
                bus.ack = 1'b1;
                state_d = IDLE;
            end
            POP_DEC: begin
                sp_we   = 1'b1;
                sp_op   = 1'b0;
                state_d = POP_RD;
            end
            POP_RD: begin
                state_d = POP_CAP;
            end
            POP_CAP: begin
                bus.ack = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with BITS=2: directed scenarios followed by random push/pop traffic.
// Expected values come from an abstract stack model (array + modular pointer/occupancy arithmetic).
module tb_stack_ctrl;
    localparam int BITS      = 2;
    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 1 << BITS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_ctrl_if #(.DATA_BITS(DATA_BITS)) bus ();

    logic [BITS-1:0]      sp;
    logic                 sp_we;
    logic                 sp_op;
    logic [BITS-1:0]      mem_addr;
    logic                 mem_we;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;
    logic [DATA_BITS-1:0] ram [DEPTH];

    stack_ctrl #(.BITS(BITS), .DATA_BITS(DATA_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sp        (sp),
        .sp_we     (sp_we),
        .sp_op     (sp_op),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Environment: the sp counter and the synchronous-read stack RAM the sequencer drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        sp <= '0;
        else if (sp_we) sp <= sp_op ? sp + BITS'(1) : sp - BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    int                   ref_sp;
    int                   ref_count;
    bit                   ref_err;
    logic [DATA_BITS-1:0] ref_rd;
    logic [DATA_BITS-1:0] ref_ram [DEPTH];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit push_rejected();
`ifdef STACK_GUARD_EN
        return ref_count == DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit pop_rejected();
`ifdef STACK_GUARD_EN
        return ref_count == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        ref_sp    = 0;
        ref_count = 0;
        ref_err   = 1'b0;
        ref_rd    = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".empty"},   32'(bus.empty),   32'(ref_count == 0));
        check({tag, ".full"},    32'(bus.full),    32'(ref_count == DEPTH));
        check({tag, ".err"},     32'(bus.err),     32'(ref_err));
        check({tag, ".sp"},      32'(sp),          32'(ref_sp));
        check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(ref_rd));
        check({tag, ".ready"},   32'(bus.ready),   32'd1);
    endtask

    task automatic apply_reset();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst      = 1'b1;
        #1;
        model_reset();
        check("rst.ready",    32'(bus.ready),    32'd1);
        check("rst.empty",    32'(bus.empty),    32'd1);
        check("rst.full",     32'(bus.full),     32'd0);
        check("rst.ack",      32'(bus.ack),      32'd0);
        check("rst.sp_we",    32'(sp_we),        32'd0);
        check("rst.mem_we",   32'(mem_we),       32'd0);
        check("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst.rd_data",  32'(bus.rd_data),  32'd0);
        check("rst.err",      32'(bus.err),      32'd0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_push(input logic [DATA_BITS-1:0] d);
        bus.push    = 1'b1;
        bus.wr_data = d;
        #1;
        check("push.ready_in", 32'(bus.ready), 32'd1);
        if (push_rejected()) begin
            check("push_rej.ack",    32'(bus.ack), 32'd1);
            check("push_rej.mem_we", 32'(mem_we),  32'd0);
            check("push_rej.sp_we",  32'(sp_we),   32'd0);
            tick();
            bus.push = 1'b0;
            ref_err  = 1'b1;
        end else begin
            check("push.ack_early", 32'(bus.ack), 32'd0);
            tick();
            bus.push = 1'b0;
            check("push.mem_we",    32'(mem_we),    32'd1);
            check("push.mem_addr",  32'(mem_addr),  32'(ref_sp));
            check("push.mem_wdata", 32'(mem_wdata), 32'(d));
            check("push.sp_we",     32'(sp_we),     32'd1);
            check("push.sp_op",     32'(sp_op),     32'd1);
            check("push.ack",       32'(bus.ack),   32'd1);
            check("push.busy",      32'(bus.ready), 32'd0);
            ref_ram[ref_sp] = d;
            ref_sp          = (ref_sp + 1) % DEPTH;
            ref_count       = (ref_count + 1) % (2 * DEPTH);
            tick();
        end
        check("push.ack_after",    32'(bus.ack), 32'd0);
        check("push.mem_we_after", 32'(mem_we),  32'd0);
        check_state("push");
    endtask

    task automatic do_pop();
        logic [DATA_BITS-1:0] exp;
        bus.pop = 1'b1;
        #1;
        check("pop.ready_in", 32'(bus.ready), 32'd1);
        if (pop_rejected()) begin
            check("pop_rej.ack",   32'(bus.ack), 32'd1);
            check("pop_rej.sp_we", 32'(sp_we),   32'd0);
            tick();
            bus.pop = 1'b0;
            ref_err = 1'b1;
            check("pop_rej.rd_valid", 32'(bus.rd_valid), 32'd0);
            check("pop_rej.ack_after", 32'(bus.ack), 32'd0);
            tick();
            check("pop_rej.rd_valid2", 32'(bus.rd_valid), 32'd0);
        end else begin
            check("pop.ack_early", 32'(bus.ack), 32'd0);
            tick();
            bus.pop = 1'b0;
            check("pop_dec.sp_we",  32'(sp_we),     32'd1);
            check("pop_dec.sp_op",  32'(sp_op),     32'd0);
            check("pop_dec.mem_we", 32'(mem_we),    32'd0);
            check("pop_dec.ack",    32'(bus.ack),   32'd0);
            check("pop_dec.busy",   32'(bus.ready), 32'd0);
            ref_sp    = (ref_sp + DEPTH - 1) % DEPTH;
            ref_count = (ref_count + 2 * DEPTH - 1) % (2 * DEPTH);
            exp       = ref_ram[ref_sp];
            tick();
            check("pop_rd.sp",       32'(sp),           32'(ref_sp));
            check("pop_rd.mem_addr", 32'(mem_addr),     32'(ref_sp));
            check("pop_rd.sp_we",    32'(sp_we),        32'd0);
            check("pop_rd.ack",      32'(bus.ack),      32'd0);
            tick();
            check("pop_cap.ack",      32'(bus.ack),      32'd1);
            check("pop_cap.rd_valid", 32'(bus.rd_valid), 32'd0);
            check("pop_cap.busy",     32'(bus.ready),    32'd0);
            tick();
            ref_rd = exp;
            check("pop.rd_valid", 32'(bus.rd_valid), 32'd1);
            check("pop.rd_data",  32'(bus.rd_data),  32'(exp));
            check("pop.ack_done", 32'(bus.ack),      32'd0);
            tick();
            check("pop.rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
        end
        check_state("pop");
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.wr_data = '0;
        model_reset();
        #2;

        // Single push after reset.
        apply_reset();
        do_push(8'hA5);

        // LIFO order.
        apply_reset();
        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_pop();
        do_pop();
        do_pop();

        // Simultaneous push and pop with one entry present: push first, pop follows.
        do_push(8'h55);
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.wr_data = 8'h44;
        #1;
        check("both.ack_early", 32'(bus.ack), 32'd0);
        tick();
        bus.push = 1'b0;
        check("both.mem_we", 32'(mem_we), 32'd1);
        check("both.sp_op",  32'(sp_op),  32'd1);
        ref_ram[ref_sp] = 8'h44;
        ref_sp          = (ref_sp + 1) % DEPTH;
        ref_count       = ref_count + 1;
        tick();
        check("both.ready", 32'(bus.ready), 32'd1);
        check("both.sp",    32'(sp),        32'(ref_sp));
        do_pop();
        do_pop();

        // Fill to full, then one push beyond.
        for (int i = 0; i < DEPTH; i++) do_push(8'hC0 + 8'(i));
        check("fill.full", 32'(bus.full), 32'd1);
        do_push(8'hEE);

        // Pop on empty.
        apply_reset();
        do_pop();

        // Reset asserted during POP_RD aborts the pop.
        apply_reset();
        do_push(8'h66);
        do_push(8'h77);
        bus.pop = 1'b1;
        #1;
        tick();
        bus.pop = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        check("abort.ready",    32'(bus.ready),    32'd1);
        check("abort.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("abort.empty",    32'(bus.empty),    32'd1);
        check("abort.rd_data",  32'(bus.rd_data),  32'd0);
        check("abort.sp_we",    32'(sp_we),        32'd0);
        check("abort.mem_we",   32'(mem_we),       32'd0);
        check("abort.ack",      32'(bus.ack),      32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort.rd_valid_hold", 32'(bus.rd_valid), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("abort.rd_valid_post", 32'(bus.rd_valid), 32'd0);
        check_state("abort");

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0: do_push(8'($urandom));
                1: do_pop();
                default: begin
                    tick();
                    check("idle.ack",      32'(bus.ack),      32'd0);
                    check("idle.rd_valid", 32'(bus.rd_valid), 32'd0);
                    check_state("idle");
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
